// File: rtl/alarm_ring_control_pkg.sv
// Shared definitions for the alarm side of the digital clock.
// - State encoding for the alarm ring sequencer.
// - Time field widths, shared with the clock/alarm time counters.
package alarm_ring_control_pkg;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam int SS_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/alarm_ring_control_sec_downcounter.sv
// Seconds down-counter used for the ring and snooze durations.
// Ports:
//   ck, reset     : clock, asynchronous active-high reset
//   load          : load load_value (takes priority over tick)
//   load_value    : value to load
//   tick          : decrement by one; holds at zero, never wraps
//   zero_next     : the current tick moves the count from 1 to 0
module alarm_ring_control_sec_downcounter
  import alarm_ring_control_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             zero_next
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_value;
    end else if (tick && (value_q != '0)) begin
      value_q <= value_q - WIDTH'(1);
    end
  end

  assign zero_next = tick && (value_q == WIDTH'(1));

endmodule

// File: rtl/alarm_ring_control.sv
// Alarm ring sequencer: fires once when the running time reaches the alarm
// time, drives the buzzer for a bounded time, and handles snooze/stop.
// Ports:
//   ck, reset                    : clock, asynchronous active-high reset
//   tick_1hz                     : one-ck pulse per second
//   clock_hh/mm/ss               : running clock time (binary)
//   alarm_hh/mm, alarm_en        : programmed alarm time and arm level
//   snooze, stop                 : debounced button levels
//   ring, snoozing, snooze_cnt   : registered buzzer drive, snooze flag,
//                                  snoozes used in the current alarm event
module alarm_ring_control
  import alarm_ring_control_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic            ck,
  input  logic            reset,
  input  logic            tick_1hz,
  input  logic [HH_W-1:0] clock_hh,
  input  logic [MM_W-1:0] clock_mm,
  input  logic [SS_W-1:0] clock_ss,
  input  logic [HH_W-1:0] alarm_hh,
  input  logic [MM_W-1:0] alarm_mm,
  input  logic            alarm_en,
  input  logic            snooze,
  input  logic            stop,
  output logic            ring,
  output logic            snoozing,
  output logic [1:0]      snooze_cnt
);

  localparam int         RT_W    = $clog2(RING_SECONDS + 1);
  localparam int         ST_W    = $clog2(SNOOZE_SECONDS + 1);
  localparam logic [1:0] MAX_CNT = 2'(MAX_SNOOZE);

  alarm_state_e state_q;
  logic         ring_q, snoozing_q;
  logic [1:0]   snooze_cnt_q;
  logic         match_q, snooze_q, stop_q;

  logic match, trigger, snooze_p, stop_p, kill;
  logic in_idle, in_ring, in_snz;
  logic snz_accept, ring_load, ring_expire, snz_expire;

  assign match = alarm_en && (clock_hh == alarm_hh) && (clock_mm == alarm_mm)
                 && (clock_ss == '0);

  // Edge detection: the alarm minute fires once, a held button pulses once.
  assign trigger  = match  && !match_q;
  assign snooze_p = snooze && !snooze_q;
  assign stop_p   = stop   && !stop_q;
  assign kill     = stop_p || !alarm_en;

  assign in_idle = (state_q == ST_IDLE);
  assign in_ring = (state_q == ST_RINGING);
  assign in_snz  = (state_q == ST_SNOOZE);

  assign snz_accept = in_ring && !kill && snooze_p && (snooze_cnt_q < MAX_CNT);
  // Ring timer reloads on a fresh alarm and when a snooze period runs out.
  assign ring_load  = (in_idle && trigger) || (in_snz && !kill && snz_expire);

  alarm_ring_control_sec_downcounter #(.WIDTH(RT_W)) u_ring_timer (
    .ck         (ck),
    .reset      (reset),
    .load       (ring_load),
    .load_value (RT_W'(RING_SECONDS)),
    .tick       (tick_1hz && in_ring),
    .zero_next  (ring_expire)
  );

  alarm_ring_control_sec_downcounter #(.WIDTH(ST_W)) u_snooze_timer (
    .ck         (ck),
    .reset      (reset),
    .load       (snz_accept),
    .load_value (ST_W'(SNOOZE_SECONDS)),
    .tick       (tick_1hz && in_snz),
    .zero_next  (snz_expire)
  );

  // Outputs are registered from the next state so they switch together
  // with the state register.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ring_q       <= 1'b0;
      snoozing_q   <= 1'b0;
      snooze_cnt_q <= 2'd0;
      match_q      <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      match_q  <= match;
      snooze_q <= snooze;
      stop_q   <= stop;
      case (state_q)
        ST_IDLE: begin
          snoozing_q <= 1'b0;
          if (trigger) begin
            state_q      <= ST_RINGING;
            ring_q       <= 1'b1;
            snooze_cnt_q <= 2'd0;
          end else begin
            ring_q <= 1'b0;
          end
        end
        ST_RINGING: begin
          if (kill || (!snz_accept && ring_expire)) begin
            state_q    <= ST_IDLE;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (snz_accept) begin
            state_q      <= ST_SNOOZE;
            ring_q       <= 1'b0;
            snoozing_q   <= 1'b1;
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
          end else begin
            ring_q     <= 1'b1;
            snoozing_q <= 1'b0;
          end
        end
        ST_SNOOZE: begin
          if (kill) begin
            state_q    <= ST_IDLE;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (snz_expire) begin
            state_q    <= ST_RINGING;
            ring_q     <= 1'b1;
            snoozing_q <= 1'b0;
          end else begin
            ring_q     <= 1'b0;
            snoozing_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ring_q     <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign ring       = ring_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_control.sv
module tb_alarm_ring_control;

  logic       ck, reset, tick_1hz, alarm_en, snooze, stop;
  logic [4:0] clock_hh, alarm_hh;
  logic [5:0] clock_mm, clock_ss, alarm_mm;
  logic       ring, snoozing;
  logic [1:0] snooze_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_ring_control #(
    .RING_SECONDS   (5),
    .SNOOZE_SECONDS (3),
    .MAX_SNOOZE     (2)
  ) dut (
    .ck         (ck),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .clock_hh   (clock_hh),
    .clock_mm   (clock_mm),
    .clock_ss   (clock_ss),
    .alarm_hh   (alarm_hh),
    .alarm_mm   (alarm_mm),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .stop       (stop),
    .ring       (ring),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    cyc();
  endtask

  // Leave the alarm second and come back to it: produces a fresh match edge.
  task automatic retrigger();
    clock_ss = 6'd1;
    cyc();
    clock_ss = 6'd0;
    cyc();
  endtask

  initial begin
    int rang;
    reset = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b1; snooze = 1'b0; stop = 1'b0;
    alarm_hh = 5'd7; alarm_mm = 6'd30;
    clock_hh = 5'd7; clock_mm = 6'd29; clock_ss = 6'd59;
    #23;
    chk("reset_ring", ring, 0);
    chk("reset_snoozing", snoozing, 0);
    chk("reset_cnt", snooze_cnt, 0);
    @(negedge ck);
    reset = 1'b0;
    cyc();

    // Basic alarm and auto-off
    chk("pre_match_ring", ring, 0);
    clock_mm = 6'd30; clock_ss = 6'd0;
    cyc();
    chk("trigger_ring", ring, 1);
    chk("trigger_cnt", snooze_cnt, 0);
    for (int i = 0; i < 4; i++) do_tick();
    chk("ring_after_4_ticks", ring, 1);
    do_tick();
    chk("autooff_ring", ring, 0);
    rang = 0;
    for (int s = 1; s < 60; s++) begin
      clock_ss = 6'(s);
      do_tick();
      if (ring) rang++;
    end
    chk("no_rering_in_minute", rang, 0);

    // Held snooze: one snooze only, re-ring after 3 ticks
    retrigger();
    chk("t2_ring", ring, 1);
    snooze = 1'b1;
    cyc();
    chk("t2_snoozing", snoozing, 1);
    chk("t2_ring_off", ring, 0);
    chk("t2_cnt", snooze_cnt, 1);
    do_tick(); do_tick();
    chk("t2_still_snoozing", snoozing, 1);
    do_tick();
    chk("t2_rering", ring, 1);
    chk("t2_snoozing_off", snoozing, 0);
    for (int i = 0; i < 4; i++) do_tick();
    chk("t2_held_no_resnooze", ring, 1);
    chk("t2_held_cnt", snooze_cnt, 1);
    do_tick();
    chk("t2_autooff", ring, 0);
    do_tick(); do_tick();
    snooze = 1'b0;
    cyc();
    chk("t2_idle_cnt_hold", snooze_cnt, 1);

    // Snooze limit
    retrigger();
    chk("t3_cnt_cleared", snooze_cnt, 0);
    pulse_snooze();
    for (int i = 0; i < 3; i++) do_tick();
    pulse_snooze();
    chk("t3_cnt2", snooze_cnt, 2);
    chk("t3_snoozing2", snoozing, 1);
    for (int i = 0; i < 3; i++) do_tick();
    chk("t3_rering2", ring, 1);
    pulse_snooze();
    chk("t3_third_ignored_ring", ring, 1);
    chk("t3_third_ignored_snz", snoozing, 0);
    chk("t3_cnt_sat", snooze_cnt, 2);
    for (int i = 0; i < 4; i++) do_tick();
    chk("t3_ring_4", ring, 1);
    do_tick();
    chk("t3_autooff", ring, 0);

    // Stop during snooze
    retrigger();
    pulse_snooze();
    chk("t4_in_snooze", snoozing, 1);
    stop = 1'b1;
    cyc();
    chk("t4_stop_snoozing", snoozing, 0);
    chk("t4_stop_ring", ring, 0);
    stop = 1'b0;
    for (int i = 0; i < 4; i++) do_tick();
    chk("t4_stays_idle", ring | snoozing, 0);

    // Disarm while ringing
    retrigger();
    chk("t4b_ring", ring, 1);
    alarm_en = 1'b0;
    cyc();
    chk("t4b_disarm_ring", ring, 0);
    chk("t4b_disarm_snz", snoozing, 0);
    clock_ss = 6'd1;
    cyc();
    alarm_en = 1'b1;
    cyc();

    // Disarmed at alarm time: no ring
    alarm_en = 1'b0;
    clock_mm = 6'd29; clock_ss = 6'd59;
    cyc();
    clock_mm = 6'd30; clock_ss = 6'd0;
    cyc(); cyc();
    chk("t5_disarmed_no_ring", ring, 0);
    clock_ss = 6'd1;
    cyc();
    alarm_en = 1'b1;
    cyc();

    // Stop and snooze together: stop wins
    retrigger();
    chk("t5b_ring", ring, 1);
    snooze = 1'b1; stop = 1'b1;
    cyc();
    chk("t5b_ring_off", ring, 0);
    chk("t5b_no_snooze", snoozing, 0);
    chk("t5b_cnt", snooze_cnt, 0);
    snooze = 1'b0; stop = 1'b0;
    cyc();

    // Asynchronous reset mid-ring
    retrigger();
    pulse_snooze();
    for (int i = 0; i < 3; i++) do_tick();
    chk("t6_ring_before_reset", ring, 1);
    chk("t6_cnt_before_reset", snooze_cnt, 1);
    clock_ss = 6'd5;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_ring", ring, 0);
    chk("t6_async_cnt", snooze_cnt, 0);
    chk("t6_async_snz", snoozing, 0);
    #1;
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("t6_no_ring_after_release", ring, 0);
    clock_ss = 6'd0;
    cyc();
    chk("t6_ring_on_next_match", ring, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ring_control.md
Name: alarm_ring_control

Overview:
- Sequences the alarm side of the digital clock: detects when the running clock time reaches the programmed alarm time, then drives the ringer.
- Handles user snooze and stop requests with bounded ring and snooze durations.
- Sits between the clock/alarm time counters and the buzzer/LED output stage; consumes the existing 1 Hz tick and debounced button levels.

Parameters:
- RING_SECONDS, 60, ticks of continuous ringing before automatic silence.
- SNOOZE_SECONDS, 300, ticks spent in snooze before re-ringing.
- MAX_SNOOZE, 3, snooze presses honoured per alarm event; further snooze presses are ignored.

Ports:
- ck  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick_1hz  input  1  one-ck-wide pulse, once per second.
- clock_hh  input  5  running clock hours, binary 0-23.
- clock_mm  input  6  running clock minutes, binary 0-59.
- clock_ss  input  6  running clock seconds, binary 0-59.
- alarm_hh  input  5  alarm hours, binary 0-23.
- alarm_mm  input  6  alarm minutes, binary 0-59.
- alarm_en  input  1  alarm armed (level).
- snooze  input  1  debounced snooze button (level).
- stop  input  1  debounced stop button (level).
- ring  output  1  buzzer drive, registered.
- snoozing  output  1  high while in SNOOZE, registered.
- snooze_cnt  output  2  snoozes used in current alarm event.

Behaviour:
- Reset (async): state=IDLE; ring=0; snoozing=0; snooze_cnt=0; all timers 0; edge-detect registers 0.
- match = alarm_en & (clock_hh==alarm_hh) & (clock_mm==alarm_mm) & (clock_ss==0).
- match_d registers match. Trigger = match & ~match_d, so each alarm minute fires exactly once, even after an early stop.
- snooze_p / stop_p are rising edges of snooze / stop, computed against a 1-cycle registered copy. A held button produces one pulse.
- States: IDLE, RINGING, SNOOZE.
- IDLE:
  - On trigger -> RINGING; ring_timer=RING_SECONDS; snooze_cnt=0.
  - snooze_p and stop_p are ignored.
- RINGING (ring=1), priority highest first:
  - stop_p or ~alarm_en -> IDLE.
  - snooze_p & snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_timer=SNOOZE_SECONDS; snooze_cnt+1.
  - snooze_p & snooze_cnt==MAX_SNOOZE -> ignored; stay in RINGING.
  - tick_1hz & ring_timer==1 -> IDLE (auto-off).
  - Otherwise, tick_1hz decrements ring_timer.
- SNOOZE (snoozing=1), priority highest first:
  - stop_p or ~alarm_en -> IDLE.
  - tick_1hz & snooze_timer==1 -> RINGING; ring_timer=RING_SECONDS.
  - Otherwise, tick_1hz decrements snooze_timer.
  - snooze_p is ignored.
- A trigger while in RINGING or SNOOZE is ignored.
- Output timing: ring and snoozing are registered from the next state, so they change in the same cycle as the state register.
  - Latency from trigger (or tick_1hz, or button edge) to output change: 1 ck.
- snooze_cnt holds its value in IDLE until the next trigger; it saturates at MAX_SNOOZE.
- Timer widths: ring_timer is clog2(RING_SECONDS+1) bits; snooze_timer is clog2(SNOOZE_SECONDS+1) bits. Timers never wrap below 0.
- Illegal state encoding -> IDLE, outputs 0.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RINGING=1, SNOOZE=2) and time field widths (HH_W=5, MM_W=6, SS_W=6), reused by the clock counters.
- One sub-module, sec_downcounter:
  - load, load_value, tick, zero_next (value==1 & tick).
  - Parameterised width.
  - Instantiated twice, for ring_timer and snooze_timer.
- Edge detection stays inline.

Test Plan (RING_SECONDS=5, SNOOZE_SECONDS=3, MAX_SNOOZE=2):
- Alarm 07:30, en=1; clock steps 07:29:59 -> 07:30:00 -> ring=1 one ck after match; ring=0 after 5 ticks; no re-ring during 07:30:01-07:30:59.
- Ringing, snooze pressed and held 10 ticks -> snoozing=1, snooze_cnt=1; ring=1 again after exactly 3 ticks; held button causes no second snooze.
- Snooze twice, then third snooze_p while ringing -> stays RINGING, snooze_cnt=2; auto-off after 5 ticks.
- stop_p in SNOOZE, and separately alarm_en=0 in RINGING -> IDLE next ck, ring=0, snoozing=0.
- alarm_en=0 at 07:30:00 -> no ring. Also: stop_p and snooze_p in the same cycle while ringing -> IDLE (stop wins).
- reset asserted mid-RINGING, asynchronously between clock edges -> ring=0, snooze_cnt=0 immediately; no ring after release until the next match edge.
